// File: rtl/imm_gen_pipe_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the pipelined RISC-V immediate generator:
//   - fmt_t        : 3-bit instruction format code carried on out_fmt
//   - OP_*         : major opcodes (instr[6:0]) recognised by the decoder
//   - DEFAULT_XLEN : default datapath width for immediate, pc and target
// ---------------------------------------------------------------------------
package imm_pkg;

    localparam int DEFAULT_XLEN = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_ILL  = 3'd7
    } fmt_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if
// Valid/ready bundle between fetch (producer), the immediate generator and
// register read (consumer).
//   in_valid/in_ready/in_instr/in_pc        : instruction side
//   out_valid/out_ready/out_imm/out_target/
//   out_fmt/out_illegal                     : decoded-bundle side
// Modports:
//   slave  : the immediate generator itself
//   master : whoever drives instructions and consumes bundles
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) ();

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    fmt_t            out_fmt;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Purely combinational classifier: instruction word -> format, illegal flag
// and sign-extended immediate.
//   i_instr   : 32-bit instruction word
//   o_fmt     : format code
//   o_illegal : opcode not recognised
//   o_imm     : immediate sign-extended to XLEN (0 for R-type and illegal)
// ---------------------------------------------------------------------------
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [31:0]     i_instr,
    output fmt_t            o_fmt,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_imm
);

    logic signed [31:0] w_imm32;

    // Opcode to format lookup; anything not listed is treated as illegal.
    always_comb begin
        o_fmt = FMT_ILL;
        case (i_instr[6:0])
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: o_fmt = FMT_I;
            OP_STORE:                           o_fmt = FMT_S;
            OP_BRANCH:                          o_fmt = FMT_B;
            OP_LUI, OP_AUIPC:                   o_fmt = FMT_U;
            OP_JAL:                             o_fmt = FMT_J;
            OP_REG, OP_REG32:                   o_fmt = FMT_NONE;
            default:                            o_fmt = FMT_ILL;
        endcase
    end

    // Every immediate fits in 32 bits, so it is assembled sign-extended to
    // 32 first and widened to XLEN in one place below.
    always_comb begin
        w_imm32 = '0;
        case (o_fmt)
            FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm     = XLEN'(w_imm32);
    assign o_illegal = (o_fmt == FMT_ILL);

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Decode-stage immediate generator with a 1-cycle registered output and a
// single skid entry, so back-pressure from register read never drops or
// duplicates an instruction.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   flush       : synchronous flush, empties both entries
//   bus         : imm_gen_pipe_if.slave handshake bundle
//   illegal_cnt : saturating count of illegal bundles handed to the consumer
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter bit TARGET_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    imm_gen_pipe_if.slave    bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fmt_t            w_decFmt;
    logic            w_decIllegal;
    logic [XLEN-1:0] w_decImm;
    logic [XLEN-1:0] w_target;
    logic            w_inFire;
    logic            w_outFire;

    logic            r_mainValid;
    logic [XLEN-1:0] r_mainImm;
    logic [XLEN-1:0] r_mainTarget;
    fmt_t            r_mainFmt;
    logic            r_mainIllegal;

    logic            r_skidValid;
    logic [XLEN-1:0] r_skidImm;
    logic [XLEN-1:0] r_skidTarget;
    fmt_t            r_skidFmt;
    logic            r_skidIllegal;

    logic [CNT_W-1:0] r_illegalCnt;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_instr   (bus.in_instr),
        .o_fmt     (w_decFmt),
        .o_illegal (w_decIllegal),
        .o_imm     (w_decImm)
    );

    // PC-relative target for branches, JAL and AUIPC. JALR is I-format and
    // needs rs1, so it gets no target here. The adder vanishes when
    // TARGET_EN is 0.
    always_comb begin
        w_target = '0;
        if (TARGET_EN && (w_decFmt == FMT_B || w_decFmt == FMT_J ||
                          bus.in_instr[6:0] == OP_AUIPC)) begin
            w_target = bus.in_pc + w_decImm;
        end
    end

    // in_ready depends only on skid occupancy, keeping out_ready off any
    // combinational path back to the producer.
    assign w_inFire  = bus.in_valid && !r_skidValid;
    assign w_outFire = r_mainValid && bus.out_ready;

    // Main/skid storage. The main register refills whenever it is empty or
    // draining, taking the skid entry first to keep order; otherwise a new
    // instruction parks in the skid entry and in_ready drops next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainValid   <= 1'b0;
            r_mainImm     <= '0;
            r_mainTarget  <= '0;
            r_mainFmt     <= FMT_NONE;
            r_mainIllegal <= 1'b0;
            r_skidValid   <= 1'b0;
            r_skidImm     <= '0;
            r_skidTarget  <= '0;
            r_skidFmt     <= FMT_NONE;
            r_skidIllegal <= 1'b0;
        end else if (flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (!r_mainValid || w_outFire) begin
            if (r_skidValid) begin
                r_mainValid   <= 1'b1;
                r_mainImm     <= r_skidImm;
                r_mainTarget  <= r_skidTarget;
                r_mainFmt     <= r_skidFmt;
                r_mainIllegal <= r_skidIllegal;
                r_skidValid   <= 1'b0;
            end else if (w_inFire) begin
                r_mainValid   <= 1'b1;
                r_mainImm     <= w_decImm;
                r_mainTarget  <= w_target;
                r_mainFmt     <= w_decFmt;
                r_mainIllegal <= w_decIllegal;
            end else begin
                r_mainValid   <= 1'b0;
            end
        end else if (w_inFire) begin
            r_skidValid   <= 1'b1;
            r_skidImm     <= w_decImm;
            r_skidTarget  <= w_target;
            r_skidFmt     <= w_decFmt;
            r_skidIllegal <= w_decIllegal;
        end
    end

    // Illegal bundles are counted when the consumer actually takes them and
    // the count sticks at all-ones. Flush does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegalCnt <= '0;
        end else if (w_outFire && r_mainIllegal && r_illegalCnt != CNT_MAX) begin
            r_illegalCnt <= r_illegalCnt + 1'b1;
        end
    end

    assign bus.in_ready    = !r_skidValid;
    assign bus.out_valid   = r_mainValid;
    assign bus.out_imm     = r_mainImm;
    assign bus.out_target  = r_mainTarget;
    assign bus.out_fmt     = r_mainFmt;
    assign bus.out_illegal = r_mainIllegal;
    assign illegal_cnt     = r_illegalCnt;

endmodule
